// File: rtl/dma_rd_scheduler.sv
// Round-robin scheduler sharing one dma_read engine among NUM_REQ loaders.
// Grants one job at a time, drives the engine command and routes its stream to the owner.
module dma_rd_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*32-1:0] i_req_addr,
    input  logic [NUM_REQ*32-1:0] i_req_len,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic [NUM_REQ-1:0]    o_req_done,
    output logic [NUM_REQ-1:0]    o_req_error,
    output logic [DATA_W-1:0]     o_stream_data,
    output logic [NUM_REQ-1:0]    o_stream_valid,
    output logic                  o_dma_start,
    output logic [31:0]           o_dma_base_addr,
    output logic [31:0]           o_dma_byte_len,
    input  logic                  i_dma_busy,
    input  logic                  i_dma_done,
    input  logic                  i_dma_error,
    input  logic [DATA_W-1:0]     i_dma_data,
    input  logic                  i_dma_valid
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned CandW = IdxW + 1;
    localparam int unsigned CntW  = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         len_q, len_d;
    logic                err_q, err_d;
    logic                done_seen_q, done_seen_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                found;
    logic [IdxW-1:0]     pick;
    logic [CandW-1:0]    cand;
    logic [31:0]         pick_addr, pick_len;
    logic                pick_bad;

    // Search upward from rr_ptr+1, wrapping, so the last owner gets lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = {1'b0, rr_ptr_q} + CandW'(i);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!found && i_req[cand[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (pick == IdxW'(k)) begin
                pick_addr = i_req_addr[32*k +: 32];
                pick_len  = i_req_len[32*k +: 32];
            end
        end
        pick_bad = (pick_len == 32'd0) || (pick_len[1:0] != 2'b00) || (pick_addr[1:0] != 2'b00);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rr_ptr_q    <= IdxW'(NUM_REQ - 1);
            grant_q     <= '0;
            base_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            done_seen_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            base_q      <= base_d;
            len_q       <= len_d;
            err_q       <= err_d;
            done_seen_q <= done_seen_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        base_d      = base_q;
        len_d       = len_q;
        err_d       = err_q;
        done_seen_d = done_seen_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    rr_ptr_d = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    base_d   = pick_addr;
                    len_d    = pick_len;
                    if (pick_bad) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (i_dma_busy) begin
                    state_d = StRun;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (i_dma_done) done_seen_d = 1'b1;
                if (i_dma_error) err_d = 1'b1;
                if (!i_dma_busy) state_d = StDone;
            end
            StDone: begin
                err_d       = 1'b0;
                done_seen_d = 1'b0;
                grant_d     = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Invalid and timeout jobs already carry err, so a missing engine done is harmless there.
    always_comb begin
        o_dma_start    = (state_q == StStart);
        o_req_done     = '0;
        o_req_error    = '0;
        o_stream_valid = '0;
        if (state_q == StDone) begin
            o_req_done  = grant_q;
            o_req_error = (err_q || !done_seen_q) ? grant_q : '0;
        end
        if ((state_q == StWaitBusy) || (state_q == StRun)) begin
            o_stream_valid = i_dma_valid ? grant_q : '0;
        end
    end

    assign o_grant         = grant_q;
    assign o_dma_base_addr = base_q;
    assign o_dma_byte_len  = len_q;
    assign o_stream_data   = i_dma_data;

endmodule

// File: tb/tb_dma_rd_scheduler.sv
// Bench for dma_rd_scheduler: behavioural engine, per-cycle job model, directed scenarios.
module tb_dma_rd_scheduler;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BUSY_TIMEOUT = 15;

    logic                  ACLK = 1'b0;
    logic                  ARESETN = 1'b0;
    logic [NUM_REQ-1:0]    i_req = '0;
    logic [NUM_REQ*32-1:0] i_req_addr = '0;
    logic [NUM_REQ*32-1:0] i_req_len = '0;
    logic [NUM_REQ-1:0]    o_grant, o_req_done, o_req_error, o_stream_valid;
    logic [DATA_W-1:0]     o_stream_data;
    logic                  o_dma_start;
    logic [31:0]           o_dma_base_addr, o_dma_byte_len;
    logic                  i_dma_busy = 1'b0, i_dma_done = 1'b0, i_dma_error = 1'b0;
    logic                  i_dma_valid = 1'b0;
    logic [DATA_W-1:0]     i_dma_data = '0;

    always #5 ACLK = ~ACLK;

    dma_rd_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .i_req(i_req), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .o_grant(o_grant), .o_req_done(o_req_done),
        .o_req_error(o_req_error), .o_stream_data(o_stream_data),
        .o_stream_valid(o_stream_valid), .o_dma_start(o_dma_start),
        .o_dma_base_addr(o_dma_base_addr), .o_dma_byte_len(o_dma_byte_len),
        .i_dma_busy(i_dma_busy), .i_dma_done(i_dma_done), .i_dma_error(i_dma_error),
        .i_dma_data(i_dma_data), .i_dma_valid(i_dma_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural engine: busy 2 cycles after start, len/4 beats, done as busy falls.
    bit eng_en   = 1'b1;
    int err_beat = -1;

    task automatic run_job(input logic [31:0] len);
        int n;
        bit abort;
        n = int'(len >> 2);
        abort = 1'b0;
        @(posedge ACLK); #1;
        i_dma_error = 1'b0;
        if (!ARESETN) abort = 1'b1;
        if (!abort) begin
            @(posedge ACLK); #1;
            if (!ARESETN) abort = 1'b1;
        end
        for (int k = 0; k < n && !abort; k++) begin
            i_dma_busy  = 1'b1;
            i_dma_valid = 1'b1;
            i_dma_data  = DATA_W'(32'hA500_0000 + k);
            if (k == err_beat) i_dma_error = 1'b1;
            @(posedge ACLK); #1;
            if (!ARESETN) abort = 1'b1;
        end
        i_dma_valid = 1'b0;
        i_dma_busy  = 1'b0;
        if (abort) begin
            i_dma_data  = '0;
            i_dma_error = 1'b0;
        end else begin
            i_dma_done = 1'b1;
            @(posedge ACLK); #1;
            i_dma_done = 1'b0;
        end
    endtask

    initial begin : engine
        forever begin
            @(negedge ACLK);
            if (o_dma_start && eng_en && ARESETN) run_job(o_dma_byte_len);
        end
    end

    // Job-level model plus observation logs used by the scenario checks.
    bit                 m_active, m_finish, m_invalid, m_busy_seen, m_done_acc, m_err_acc;
    bit                 m_exp_err;
    int                 m_age, m_owner, m_rr;
    logic [31:0]        m_base, m_len, la, ll;
    logic [NUM_REQ-1:0] exp_grant;
    bit                 window;

    int          done_cnt = 0, start_cnt = 0, last_done_cyc = 0, last_start_cyc = 0;
    int          beats [NUM_REQ];
    int          grant_log[$];
    bit          last_err;
    int          min_gap = 1000, low_run = 0;
    bit          seen_start = 1'b0;
    logic [31:0] start_base, start_len;

    task automatic model_reset();
        m_active = 0; m_finish = 0; m_invalid = 0; m_busy_seen = 0;
        m_done_acc = 0; m_err_acc = 0; m_exp_err = 0; m_age = 0; m_owner = 0;
        m_rr = NUM_REQ - 1; m_base = '0; m_len = '0;
    endtask

    initial begin : compare
        model_reset();
        for (int k = 0; k < NUM_REQ; k++) beats[k] = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            chk("stream_data", 64'(o_stream_data), 64'(i_dma_data));
            if (!ARESETN) begin
                chk("rst_outputs", {o_grant, o_req_done, o_req_error, o_stream_valid, o_dma_start},
                    '0);
                chk("rst_cmd", {o_dma_base_addr, o_dma_byte_len}, '0);
                model_reset();
                seen_start = 1'b0;
            end else begin
                exp_grant = m_active ? NUM_REQ'(1) << m_owner : '0;
                window    = m_active && !m_invalid && m_age >= 1 && !m_finish;
                chk("grant", 64'(o_grant), 64'(exp_grant));
                chk("dma_start", 64'(o_dma_start),
                    64'(m_active && !m_invalid && !m_finish && m_age == 0));
                chk("req_done", 64'(o_req_done), 64'((m_active && m_finish) ? exp_grant : '0));
                chk("req_error", 64'(o_req_error),
                    64'((m_active && m_finish && m_exp_err) ? exp_grant : '0));
                chk("stream_valid", 64'(o_stream_valid),
                    64'((window && i_dma_valid) ? exp_grant : '0));
                chk("base_addr", 64'(o_dma_base_addr), 64'(m_base));
                chk("byte_len", 64'(o_dma_byte_len), 64'(m_len));

                if (o_dma_start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                    start_base = o_dma_base_addr;
                    start_len  = o_dma_byte_len;
                    if (seen_start && low_run < min_gap) min_gap = low_run;
                    seen_start = 1'b1;
                    low_run = 0;
                end else begin
                    low_run++;
                end
                for (int k = 0; k < NUM_REQ; k++) if (o_stream_valid[k]) beats[k]++;
                if (|o_req_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    last_err = |o_req_error;
                    for (int k = 0; k < NUM_REQ; k++) if (o_req_done[k]) grant_log.push_back(k);
                end

                if (m_active) begin
                    if (m_finish) begin
                        m_active = 0;
                        m_finish = 0;
                    end else if (m_age == 0) begin
                        m_age = 1;
                    end else if (!m_busy_seen) begin
                        if (i_dma_busy) m_busy_seen = 1;
                        else if (m_age == int'(BUSY_TIMEOUT)) begin
                            m_finish = 1;
                            m_exp_err = 1;
                        end
                        m_age++;
                    end else begin
                        m_done_acc |= i_dma_done;
                        m_err_acc  |= i_dma_error;
                        if (!i_dma_busy) begin
                            m_finish = 1;
                            m_exp_err = m_err_acc | !m_done_acc;
                        end
                    end
                end else begin
                    for (int i = 1; i <= NUM_REQ; i++) begin
                        int c;
                        c = (m_rr + i) % NUM_REQ;
                        if (!m_active && i_req[c]) begin
                            la = i_req_addr[32*c +: 32];
                            ll = i_req_len[32*c +: 32];
                            m_active = 1; m_owner = c; m_rr = c; m_base = la; m_len = ll;
                            m_invalid = (ll == 0) || (ll % 4 != 0) || (la % 4 != 0);
                            m_finish = m_invalid; m_exp_err = m_invalid; m_age = 0;
                            m_busy_seen = 0; m_done_acc = 0; m_err_acc = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int k, input logic [31:0] addr, input logic [31:0] len);
        i_req_addr[32*k +: 32] = addr;
        i_req_len[32*k +: 32]  = len;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!(|o_req_done) && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        #1;
        if (n >= bound) chk({name, "_timeout"}, 64'(n), 64'(bound - 1));
    endtask

    task automatic drop_req();
        @(posedge ACLK); #1;
        i_req = '0;
    endtask

    int s0, b0, b1, d0, req_cyc, delta;

    initial begin : stimulus
        repeat (3) @(negedge ACLK);
        chk("reset_grant", 64'(o_grant), 64'd0);
        chk("reset_start", 64'(o_dma_start), 64'd0);
        @(posedge ACLK); #2;
        ARESETN = 1'b1;

        // Single job on requester 0.
        s0 = start_cnt; b0 = beats[0]; b1 = beats[1];
        set_req(0, 32'h1000, 32'd64);
        @(posedge ACLK); #1; i_req = 2'b01;
        wait_done("t1", 100);
        chk("t1_done_idx", 64'(o_req_done), 64'h1);
        chk("t1_err", 64'(last_err), 64'd0);
        chk("t1_starts", 64'(start_cnt - s0), 64'd1);
        chk("t1_base", 64'(start_base), 64'h1000);
        chk("t1_len", 64'(start_len), 64'd64);
        chk("t1_beats0", 64'(beats[0] - b0), 64'd16);
        chk("t1_beats1", 64'(beats[1] - b1), 64'd0);
        drop_req();
        repeat (3) @(posedge ACLK);

        // Both held from reset: alternate 0,1,0,1.
        #2; ARESETN = 1'b0;
        set_req(0, 32'h2000, 32'd8);
        set_req(1, 32'h3000, 32'd12);
        i_req = 2'b11;
        repeat (2) @(posedge ACLK);
        #2; ARESETN = 1'b1;
        grant_log.delete();
        min_gap = 1000;
        for (int j = 0; j < 4; j++) begin
            wait_done("t2", 100);
            if (j < 3) @(posedge ACLK);
        end
        drop_req();
        chk("t2_njobs", 64'(grant_log.size()), 64'd4);
        for (int j = 0; j < 4 && j < grant_log.size(); j++)
            chk("t2_grant_order", 64'(grant_log[j]), 64'(j % 2));
        chk("t2_start_gap_ge2", 64'(min_gap >= 2), 64'd1);
        repeat (3) @(posedge ACLK);

        // Invalid requests on requester 1: no start, error done shortly after.
        for (int v = 0; v < 3; v++) begin
            case (v)
                0: set_req(1, 32'h4000, 32'd6);
                1: set_req(1, 32'h4000, 32'd0);
                default: set_req(1, 32'h1002, 32'd8);
            endcase
            s0 = start_cnt;
            @(posedge ACLK); #1; i_req = 2'b10;
            req_cyc = cyc + 1;
            wait_done("t3", 20);
            delta = last_done_cyc - req_cyc;
            chk("t3_latency", 64'(delta >= 1 && delta <= 2), 64'd1);
            chk("t3_no_start", 64'(start_cnt - s0), 64'd0);
            chk("t3_err", 64'(last_err), 64'd1);
            chk("t3_done_idx", 64'(o_req_done), 64'h2);
            drop_req();
            repeat (2) @(posedge ACLK);
        end

        // Engine error during RUN, then a clean job.
        err_beat = 3;
        set_req(0, 32'h5000, 32'd32);
        @(posedge ACLK); #1; i_req = 2'b01;
        wait_done("t4a", 100);
        chk("t4_err_job", 64'(last_err), 64'd1);
        drop_req();
        err_beat = -1;
        repeat (2) @(posedge ACLK);
        #1; i_req = 2'b01;
        wait_done("t4b", 100);
        chk("t4_clean_job", 64'(last_err), 64'd0);
        drop_req();
        repeat (2) @(posedge ACLK);

        // Engine never goes busy: timeout.
        eng_en = 1'b0;
        set_req(1, 32'h6000, 32'd16);
        @(posedge ACLK); #1; i_req = 2'b10;
        wait_done("t5", 60);
        chk("t5_timeout_cycles", 64'(last_done_cyc - (last_start_cyc + 1)), 64'(BUSY_TIMEOUT));
        chk("t5_err", 64'(last_err), 64'd1);
        drop_req();
        eng_en = 1'b1;
        repeat (2) @(posedge ACLK);

        // Reset during RUN.
        set_req(0, 32'h7000, 32'd64);
        @(posedge ACLK); #1; i_req = 2'b01;
        for (int n = 0; n < 40 && !i_dma_busy; n++) @(posedge ACLK);
        chk("t6_reached_busy", 64'(i_dma_busy), 64'd1);
        repeat (4) @(posedge ACLK);
        d0 = done_cnt;
        #2; ARESETN = 1'b0; i_req = '0;
        @(negedge ACLK); #1;
        chk("t6_rst_grant", 64'(o_grant), 64'd0);
        chk("t6_rst_valid", 64'(o_stream_valid), 64'd0);
        chk("t6_rst_base", 64'(o_dma_base_addr), 64'd0);
        repeat (2) @(posedge ACLK);
        #2; ARESETN = 1'b1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        repeat (2) @(posedge ACLK);
        b0 = beats[0];
        set_req(0, 32'h7000, 32'd16);
        #1; i_req = 2'b01;
        wait_done("t6b", 100);
        chk("t6_after_err", 64'(last_err), 64'd0);
        chk("t6_after_beats", 64'(beats[0] - b0), 64'd4);
        drop_req();
        repeat (3) @(posedge ACLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
